// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: datapath widths plus the load/store unit's
// state encoding and word-alignment helpers.
package rv32i_pkg;

  localparam int DPW = 32;
  localparam int ADW = 5;

  localparam logic [1:0] MEM_ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } mem_state_t;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return (lsb & MEM_ALIGN_MASK) == 2'b00;
  endfunction

  function automatic logic [DPW-1:0] word_addr(input logic [DPW-1:0] a);
    return a & ~DPW'(MEM_ALIGN_MASK);
  endfunction

endpackage

// File: rtl/data_mem_access.sv
// Memory-stage load/store unit: drives the data bus with a req/gnt/rvalid
// handshake, stalls M while an access is outstanding and produces the W registers.
module data_mem_access
  import rv32i_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           validM,
  input  logic           regwriteM,
  input  logic           resultsrcM,
  input  logic           memwriteM,
  input  logic [DPW-1:0] aluresultM,
  input  logic [DPW-1:0] Rd2M,
  input  logic [ADW-1:0] RdM,
  output logic           mem_req_o,
  output logic           mem_we_o,
  output logic [DPW-1:0] mem_addr_o,
  output logic [DPW-1:0] mem_wdata_o,
  input  logic           mem_gnt_i,
  input  logic           mem_rvalid_i,
  input  logic [DPW-1:0] mem_rdata_i,
  output logic           stall_o,
  output logic           regwriteW,
  output logic [ADW-1:0] RdW,
  output logic [DPW-1:0] resultW,
  output logic           misalign_o
);

  mem_state_t     state_q, state_d;
  logic           req_q, req_d;
  logic           we_q, we_d;
  logic [DPW-1:0] addr_q, addr_d;
  logic [DPW-1:0] wdata_q, wdata_d;
  logic           regwrite_q, regwrite_d;
  logic [ADW-1:0] rd_q, rd_d;
  logic [DPW-1:0] result_q, result_d;
  logic           misalign_q, misalign_d;

  logic memop;
  logic aligned;
  logic rsp_done;
  logic stall;

  assign memop    = validM & (resultsrcM | memwriteM);
  assign aligned  = is_word_aligned(aluresultM[1:0]);
  assign rsp_done = (state_q == WAIT) & mem_rvalid_i;
  // Held through the response cycle's edge only if the response is absent,
  // so the completing edge is also the W capture edge.
  assign stall    = memop & aligned & ~rsp_done;

  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (memop && aligned) begin
          state_d = REQ;
          req_d   = 1'b1;
          we_d    = memwriteM;
          addr_d  = word_addr(aluresultM);
          wdata_d = Rd2M;
        end
      end
      REQ: begin
        if (mem_gnt_i) state_d = WAIT;
        else           req_d   = 1'b1;
      end
      WAIT: begin
        if (mem_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    regwrite_d = 1'b0;
    rd_d       = rd_q;
    result_d   = result_q;
    misalign_d = memop & ~aligned;
    if (!stall) begin
      // A misaligned access is dropped: it never reaches the register file.
      regwrite_d = validM & regwriteM & ~(memop & ~aligned);
      rd_d       = RdM;
      result_d   = resultsrcM ? mem_rdata_i : aluresultM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      result_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      result_q   <= result_d;
      misalign_q <= misalign_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign stall_o     = stall;
  assign regwriteW   = regwrite_q;
  assign RdW         = rd_q;
  assign resultW     = result_q;
  assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_data_mem_access.sv
// Scoreboard bench for data_mem_access: a driver pushes expected W writes,
// a bus responder models memory, and a monitor pops and compares.
module tb_data_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        validM, regwriteM, resultsrcM, memwriteM;
  logic [31:0] aluresultM, Rd2M;
  logic [4:0]  RdM;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o, regwriteW, misalign_o;
  logic [4:0]  RdW;
  logic [31:0] resultW;

  data_mem_access dut (
    .clk(clk), .rst_n(rst_n),
    .validM(validM), .regwriteM(regwriteM), .resultsrcM(resultsrcM), .memwriteM(memwriteM),
    .aluresultM(aluresultM), .Rd2M(Rd2M), .RdM(RdM),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .regwriteW(regwriteW), .RdW(RdW), .resultW(resultW), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [31:0] val; } exp_t;
  exp_t q[$];

  int errors = 0;
  int checks = 0;
  int grants = 0;
  int exp_grants = 0;

  logic [31:0] exp_addr = 0, exp_wdata = 0;
  logic        exp_we = 0;
  int          gnt_delay = 0, rv_delay = 0;

  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] v;
    if (mem.exists(a)) v = mem[a];
    else               v = {a[15:0], ~a[15:0]};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Bus responder: grant after gnt_delay REQ cycles, respond rv_delay cycles later.
  initial begin
    int ph = 0, cnt = 0;
    logic [31:0] r_addr = 0, r_wd = 0;
    logic r_we = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    forever begin
      @(negedge clk);
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom;
      if (ph == 0) begin
        if (mem_req_o === 1'b1) begin
          if (cnt >= gnt_delay) begin
            mem_gnt_i = 1'b1;
            r_addr = mem_addr_o; r_we = mem_we_o; r_wd = mem_wdata_o;
            ph = 1; cnt = 0;
          end else cnt++;
        end
      end else begin
        if (cnt >= rv_delay) begin
          mem_rvalid_i = 1'b1;
          if (r_we) mem[r_addr] = r_wd;
          else      mem_rdata_i = mem_rd(r_addr);
          ph = 0; cnt = 0;
        end else cnt++;
      end
    end
  end

  // Monitor: W writes against scoreboard, bus fields against the active op.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (regwriteW === 1'b1) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_w_write: got rd=%0d val=%h expected no write", RdW, resultW);
        end else begin
          e = q.pop_front();
          chk("w_rd", {27'd0, RdW}, {27'd0, e.rd});
          chk("w_result", resultW, e.val);
        end
      end
      if (mem_req_o === 1'b1) begin
        chk("bus_addr", mem_addr_o, exp_addr);
        chk("bus_we", {31'd0, mem_we_o}, {31'd0, exp_we});
        if (exp_we) chk("bus_wdata", mem_wdata_o, exp_wdata);
        if (mem_gnt_i) grants++;
      end
    end
  end

  task automatic do_op(input bit v, input bit rw, input bit rs, input bit mw,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                       input int gd, input int rvd, input string nm);
    int st = 0;
    bit done = 0;
    bit memop, mis;
    exp_t e;
    @(negedge clk);
    validM = v; regwriteM = rw; resultsrcM = rs; memwriteM = mw;
    aluresultM = alu; Rd2M = wd; RdM = rd;
    gnt_delay = gd; rv_delay = rvd;
    memop = v && (rs || mw);
    mis   = memop && (alu[1:0] != 2'b00);
    if (memop && !mis) begin
      exp_addr = alu; exp_we = mw; exp_wdata = wd; exp_grants++;
    end
    if (v && rw && !mis) begin
      e.rd  = rd;
      e.val = (rs && !mw) ? mem_rd(alu) : alu;
      q.push_back(e);
    end
    for (int c = 0; c < 300 && !done; c++) begin
      #1;
      if (stall_o) st++;
      else         done = 1;
      @(posedge clk);
      if (!done) @(negedge clk);
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got stall still high expected release", nm);
    end
    chk({nm, "_stall_cycles"}, st, (memop && !mis) ? gd + rvd + 2 : 0);
    #1;
    chk({nm, "_misalign"}, {31'd0, misalign_o}, {31'd0, mis});
  endtask

  task automatic idle_inputs();
    validM = 0; regwriteM = 0; resultsrcM = 0; memwriteM = 0;
    aluresultM = 0; Rd2M = 0; RdM = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    idle_inputs();
    mem[32'h100] = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {31'd0, mem_req_o}, 0);
    chk("rst_we", {31'd0, mem_we_o}, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_regwrite", {31'd0, regwriteW}, 0);
    chk("rst_rd", {27'd0, RdW}, 0);
    chk("rst_result", resultW, 0);
    chk("rst_misalign", {31'd0, misalign_o}, 0);
    @(negedge clk);
    rst_n = 1;

    //           v rw rs mw alu            wd             rd  gd rvd
    do_op(1, 1, 0, 0, 32'h0000_1234, 32'h0,         5'd5,  0, 0, "alu");
    do_op(1, 1, 1, 0, 32'h0000_0100, 32'h0,         5'd7,  0, 0, "load0");
    do_op(1, 0, 0, 1, 32'h0000_0200, 32'h0000_CAFE, 5'd9,  3, 2, "store_slow");
    do_op(1, 1, 1, 0, 32'h0000_0102, 32'h0,         5'd3,  0, 0, "load_misal");
    do_op(1, 1, 1, 0, 32'h0000_0200, 32'h0,         5'd11, 1, 1, "load_back");
    do_op(1, 1, 0, 1, 32'h0000_0204, 32'h1111_2222, 5'd12, 0, 3, "store_rw");
    do_op(1, 1, 0, 1, 32'h0000_0203, 32'h5555_5555, 5'd13, 0, 0, "store_misal");
    do_op(0, 1, 0, 1, 32'h0000_0300, 32'h7777_7777, 5'd14, 0, 0, "bubble");
    do_op(1, 1, 1, 0, 32'h0000_0204, 32'h0,         5'd15, 2, 0, "load_b2b");
    do_op(1, 1, 0, 0, 32'hFFFF_FFFF, 32'h0,         5'd31, 0, 0, "alu_max");

    // Reset while waiting for a response; the late response must be ignored.
    @(negedge clk);
    validM = 1; regwriteM = 1; resultsrcM = 1; memwriteM = 0;
    aluresultM = 32'h300; RdM = 5'd20;
    gnt_delay = 0; rv_delay = 6;
    exp_addr = 32'h300; exp_we = 0; exp_grants++;
    repeat (2) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst_req", {31'd0, mem_req_o}, 0);
    chk("midrst_addr", mem_addr_o, 0);
    chk("midrst_rd", {27'd0, RdW}, 0);
    chk("midrst_result", resultW, 0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
    repeat (10) @(negedge clk);
    #1;
    chk("stray_rvalid_regwrite", {31'd0, regwriteW}, 0);
    chk("stray_rvalid_result", resultW, 0);

    for (int i = 0; i < 1000; i++) begin
      int k;
      logic [31:0] a;
      k = $urandom_range(0, 9);
      a = 32'h40 + 32'($urandom_range(0, 15)) * 4;
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      if (k <= 3)
        do_op(1, $urandom_range(0, 1), 0, 0, $urandom, $urandom, 5'($urandom), 0, 0, "r_alu");
      else if (k <= 6)
        do_op(1, $urandom_range(0, 3) != 0, 1, 0, a, $urandom, 5'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), "r_load");
      else if (k <= 8)
        do_op(1, $urandom_range(0, 1), 0, 1, a, $urandom, 5'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), "r_store");
      else
        do_op(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              a, $urandom, 5'($urandom), 0, 0, "r_bubble");
    end

    @(negedge clk);
    idle_inputs();
    repeat (4) @(negedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    chk("grant_count", grants, exp_grants);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_access.md
# data_mem_access

Load/store access unit that consumes the memory-stage pipeline register outputs and drives the data-memory bus through a request/grant/response handshake. It produces the writeback-stage register outputs (result, destination, write enable) and stalls the upstream pipeline while a load or store is outstanding. Non-memory instructions pass through with one cycle of latency.

## Interface
- DPW, from rv32i_pkg (32): data/address width.
- ADW, from rv32i_pkg (5): register index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- validM  in  1  M-stage holds a live instruction.
- regwriteM  in  1  instruction writes rd.
- resultsrcM  in  1  1 = load (result from memory), 0 = ALU result.
- memwriteM  in  1  store.
- aluresultM  in  DPW  ALU result / effective address.
- Rd2M  in  DPW  store data.
- RdM  in  ADW  destination register.
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  DPW  word address (bits [1:0] always 0).
- mem_wdata_o  out  DPW  write data.
- mem_gnt_i  in  1  request accepted this cycle.
- mem_rvalid_i  in  1  response valid (loads and stores).
- mem_rdata_i  in  DPW  load data.
- stall_o  out  1  upstream must hold M inputs stable.
- regwriteW  out  1  writeback enable.
- RdW  out  ADW  writeback register.
- resultW  out  DPW  writeback data.
- misalign_o  out  1  one-cycle pulse: misaligned access dropped.

## Operation
- memop = validM & (resultsrcM | memwriteM).
- FSM states, held in mem_state_t:
  - IDLE: if memop and aluresultM[1:0]==0, go to REQ and latch addr, wdata, and we=memwriteM. Otherwise stay in IDLE.
  - REQ: mem_req_o=1. On mem_gnt_i go to WAIT, else stay in REQ.
  - WAIT: on mem_rvalid_i, capture the W registers and go to IDLE.
- mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o are driven from registers. They hold constant while in REQ. Outside REQ, mem_req_o=0.
- stall_o is combinational: memop & aligned & !(state==WAIT & mem_rvalid_i).
- W capture on every non-stalled edge:
  - regwriteW ← validM & regwriteM
  - RdW ← RdM
  - resultW ← resultsrcM ? mem_rdata_i : aluresultM
- On a stalled edge, W takes a bubble: regwriteW←0, RdW/resultW hold.
- Stores complete on mem_rvalid_i. mem_rdata_i is ignored for stores. A store with regwriteM=1 writes aluresultM.
- Misaligned memop (aluresultM[1:0]!=0):
  - no bus request, no stall;
  - misalign_o=1 on the next cycle;
  - regwriteW←0.
- mem_rvalid_i outside WAIT is ignored. mem_gnt_i outside REQ is ignored.

## Timing
- Reset values: FSM=IDLE; mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0; regwriteW=0, RdW=0, resultW=0; misalign_o=0.
- ALU op: inputs at edge N appear on W outputs after edge N+1 (1-cycle latency).
- Memory op, best case: detect in cycle 0; REQ with gnt in cycle 1; rvalid in cycle 2. W is valid after the cycle-2 edge and stall_o is low in cycle 2. Total latency is 3 cycles.
- Each extra cycle without gnt or rvalid adds one cycle. There is no timeout.
- Back-to-back memory ops: the second op is detected in the cycle after the first completes, with no idle gap beyond IDLE detection.
- Reset mid-transaction: asynchronous return to IDLE with mem_req_o dropped immediately. A late response after reset is ignored.

## Structure
- rv32i_pkg gains the mem_state_t enum {IDLE, REQ, WAIT} and a MEM_ALIGN_MASK constant (2'b11). DPW and ADW already live there.
- A single module with no sub-module. The FSM and W registers are small enough to stay flat.

## Test plan
- ALU pass-through: aluresultM=0x0000_1234, RdM=5, regwriteM=1, resultsrcM=0 → one cycle later resultW=0x1234, RdW=5, regwriteW=1; stall_o never set.
- Load, zero wait: aluresultM=0x100, resultsrcM=1; gnt in cycle 1; rvalid with rdata=0xDEAD_BEEF in cycle 2 → mem_addr_o=0x100, mem_we_o=0; stall_o high in cycles 0–1; resultW=0xDEADBEEF after cycle 2.
- Store, slow bus: memwriteM=1, addr 0x200, Rd2M=0xCAFE; gnt delayed 3 cycles, rvalid 2 cycles later → mem_wdata_o=0xCAFE held stable through REQ; stall_o released only in the rvalid cycle; regwriteW=0.
- Misaligned load at 0x102 → mem_req_o stays 0, misalign_o pulses for 1 cycle, no stall, regwriteW=0.
- Reset asserted in WAIT, then rvalid arrives → outputs return to reset values at once; the stray rvalid causes no W update.
- Random interleave of 1000 ALU/load/store ops against a memory model with random gnt/rvalid delays → W trace matches the reference model; each memop issues exactly one mem_req_o grant.
